// File: rtl/inter_arbiter.sv
// Two-master / two-slave register-write arbiter: per-master packet FIFOs,
// round-robin grant, valid/ready delivery to the selected slave and a completion strobe.
//
// Handshakes: a master push happens when in_valid_x && in_ready_x at posedge; a slave
// transfer completes when valid_slaveX && ready_slaveX at posedge. Valid and data stay
// stable until completion, and ready on the non-addressed slave is ignored.

module inter_arbiter_fifo #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [6:0] data_i,
    output logic [6:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [6:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

module inter_arbiter #(
    parameter int DEPTH = 2  // legal range 2..8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_1,
    input  logic       in_valid_2,
    input  logic [6:0] data_in_1,
    input  logic [6:0] data_in_2,
    output logic       in_ready_1,
    output logic       in_ready_2,
    input  logic       ready_slave1,
    input  logic       ready_slave2,
    output logic       valid_slave1,
    output logic       valid_slave2,
    output logic [2:0] addr_out,
    output logic [2:0] value_out,
    output logic       handshake_slave1,
    output logic       handshake_slave2,
    output logic [1:0] grant,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HS   = 2'd2
    } state_t;

    state_t     state_q;
    logic       last_m2_q;
    logic [1:0] grant_q;
    logic       valid1_q, valid2_q;
    logic       hs1_q, hs2_q;
    logic [2:0] addr_q, value_q;

    logic       full_1, full_2, empty_1, empty_2;
    logic [6:0] head_1, head_2, head_sel;
    logic       push_1, push_2, pick_1, pick_2, arb_en, fire;

    // No bypass: a full FIFO refuses a push even while it is being popped.
    assign in_ready_1 = !full_1 && !rst;
    assign in_ready_2 = !full_2 && !rst;
    assign push_1     = in_valid_1 && in_ready_1;
    assign push_2     = in_valid_2 && in_ready_2;

    // On a tie the master that was not served last wins.
    assign arb_en   = (state_q == ST_IDLE) || (state_q == ST_HS);
    assign pick_1   = arb_en && !empty_1 && (empty_2 || last_m2_q);
    assign pick_2   = arb_en && !empty_2 && (empty_1 || !last_m2_q);
    assign head_sel = pick_1 ? head_1 : head_2;
    assign fire     = (valid1_q && ready_slave1) || (valid2_q && ready_slave2);

    inter_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_1),
        .pop_i   (pick_1),
        .data_i  (data_in_1),
        .head_o  (head_1),
        .full_o  (full_1),
        .empty_o (empty_1)
    );

    inter_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_2),
        .pop_i   (pick_2),
        .data_i  (data_in_2),
        .head_o  (head_2),
        .full_o  (full_2),
        .empty_o (empty_2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_m2_q <= 1'b1;
            grant_q   <= 2'b00;
            valid1_q  <= 1'b0;
            valid2_q  <= 1'b0;
            hs1_q     <= 1'b0;
            hs2_q     <= 1'b0;
            addr_q    <= 3'd0;
            value_q   <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HS: begin
                    hs1_q <= 1'b0;
                    hs2_q <= 1'b0;
                    if (pick_1 || pick_2) begin
                        state_q   <= ST_SEND;
                        last_m2_q <= pick_2;
                        grant_q   <= pick_1 ? 2'b01 : 2'b10;
                        valid1_q  <= !head_sel[6];
                        valid2_q  <= head_sel[6];
                        addr_q    <= head_sel[5:3];
                        value_q   <= head_sel[2:0];
                    end else begin
                        state_q  <= ST_IDLE;
                        grant_q  <= 2'b00;
                        valid1_q <= 1'b0;
                        valid2_q <= 1'b0;
                        addr_q   <= 3'd0;
                        value_q  <= 3'd0;
                    end
                end
                ST_SEND: begin
                    // Address/value stay up through HS to show the completed packet.
                    if (fire) begin
                        state_q  <= ST_HS;
                        valid1_q <= 1'b0;
                        valid2_q <= 1'b0;
                        hs1_q    <= valid1_q;
                        hs2_q    <= valid2_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign valid_slave1     = valid1_q;
    assign valid_slave2     = valid2_q;
    assign addr_out         = addr_q;
    assign value_out        = value_q;
    assign handshake_slave1 = hs1_q;
    assign handshake_slave2 = hs2_q;
    assign grant            = grant_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_inter_arbiter.sv
// Directed bench for inter_arbiter: single packet, tie-break, backpressure,
// FIFO full, round-robin stress and mid-transfer reset.

module tb_inter_arbiter;
  logic       clk;
  logic       rst;
  logic       in_valid_1, in_valid_2;
  logic [6:0] data_in_1, data_in_2;
  logic       in_ready_1, in_ready_2;
  logic       ready_slave1, ready_slave2;
  logic       valid_slave1, valid_slave2;
  logic [2:0] addr_out, value_out;
  logic       handshake_slave1, handshake_slave2;
  logic [1:0] grant;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_hs_cyc = -1;
  bit rr_mode = 0;

  // Scoreboard item: {grant, sel, addr, value} of each completed packet, in order.
  logic [8:0] exp_q[$];

  inter_arbiter #(.DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid_1       (in_valid_1),
    .in_valid_2       (in_valid_2),
    .data_in_1        (data_in_1),
    .data_in_2        (data_in_2),
    .in_ready_1       (in_ready_1),
    .in_ready_2       (in_ready_2),
    .ready_slave1     (ready_slave1),
    .ready_slave2     (ready_slave2),
    .valid_slave1     (valid_slave1),
    .valid_slave2     (valid_slave2),
    .addr_out         (addr_out),
    .value_out        (value_out),
    .handshake_slave1 (handshake_slave1),
    .handshake_slave2 (handshake_slave2),
    .grant            (grant),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid1"}, 32'(valid_slave1), 32'd0);
    check({tag, "_valid2"}, 32'(valid_slave2), 32'd0);
    check({tag, "_hs"}, 32'({handshake_slave1, handshake_slave2}), 32'd0);
    check({tag, "_addr"}, 32'(addr_out), 32'd0);
    check({tag, "_value"}, 32'(value_out), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic do_reset();
    exp_q.delete();
    rst = 1'b1;
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    tick();
    check_idle("rst");
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_in_ready", 32'({in_ready_1, in_ready_2}), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'({in_ready_1, in_ready_2}), 32'd3);
  endtask

  // ---------------- driver ----------------
  task automatic push_pkt(input int m, input logic [6:0] d);
    logic acc;
    acc = 1'b0;
    if (m == 1) begin in_valid_1 = 1'b1; data_in_1 = d; end
    else begin in_valid_2 = 1'b1; data_in_2 = d; end
    for (int n = 0; n < 100; n++) begin
      acc = (m == 1) ? in_ready_1 : in_ready_2;
      tick();
      if (acc) break;
    end
    if (m == 1) in_valid_1 = 1'b0;
    else in_valid_2 = 1'b0;
    if (!acc) check("push_timeout", 32'(m), 32'd0);
  endtask

  task automatic drain(input int max_cycles);
    for (int n = 0; n < max_cycles && exp_q.size() != 0; n++) tick();
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (valid_slave1 || valid_slave2)
      check("one_valid", 32'(valid_slave1 && valid_slave2), 32'd0);
    if (handshake_slave1 || handshake_slave2) begin
      check("hs_both", 32'(handshake_slave1 && handshake_slave2), 32'd0);
      if (exp_q.size() == 0) begin
        check("hs_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("hs_pkt", 32'({grant, handshake_slave2, addr_out, value_out}), 32'(e));
      end
      if (rr_mode && last_hs_cyc >= 0) check("hs_gap", 32'(cyc - last_hs_cyc), 32'd2);
      last_hs_cyc = cyc;
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    data_in_1 = 7'd0; data_in_2 = 7'd0;
    ready_slave1 = 1'b1; ready_slave2 = 1'b1;
    tick();

    // Single packet
    do_reset();
    exp_q.push_back({2'b01, 7'b0_101_011});
    push_pkt(1, 7'b0_101_011);
    check("t1_lat_valid", 32'(valid_slave1), 32'd0);
    tick();
    check("t1_valid1", 32'(valid_slave1), 32'd1);
    check("t1_valid2", 32'(valid_slave2), 32'd0);
    check("t1_addr", 32'(addr_out), 32'd5);
    check("t1_value", 32'(value_out), 32'd3);
    check("t1_grant", 32'(grant), 32'd1);
    check("t1_state", 32'(dbg_state), 32'd1);
    tick();
    check("t1_hs1", 32'(handshake_slave1), 32'd1);
    check("t1_hs_valid", 32'(valid_slave1), 32'd0);
    check("t1_hs_addr", 32'(addr_out), 32'd5);
    check("t1_hs_grant", 32'(grant), 32'd1);
    tick();
    check_idle("t1_idle");

    // Simultaneous request: master 1 wins the first tie
    do_reset();
    exp_q.push_back({2'b01, 7'b1_010_110});
    exp_q.push_back({2'b10, 7'b0_111_001});
    fork
      push_pkt(1, 7'b1_010_110);
      push_pkt(2, 7'b0_111_001);
    join
    tick();
    check("t2_a_valid2", 32'(valid_slave2), 32'd1);
    check("t2_a_addr", 32'(addr_out), 32'd2);
    check("t2_a_value", 32'(value_out), 32'd6);
    check("t2_a_grant", 32'(grant), 32'd1);
    tick();
    check("t2_a_hs2", 32'(handshake_slave2), 32'd1);
    tick();
    check("t2_b_valid1", 32'(valid_slave1), 32'd1);
    check("t2_b_addr", 32'(addr_out), 32'd7);
    check("t2_b_value", 32'(value_out), 32'd1);
    check("t2_b_grant", 32'(grant), 32'd2);
    tick();
    check("t2_b_hs1", 32'(handshake_slave1), 32'd1);
    tick();
    check_idle("t2_idle");

    // Backpressure on slave 2; ready on slave 1 must be ignored
    do_reset();
    ready_slave2 = 1'b0;
    exp_q.push_back({2'b01, 7'b1_011_100});
    push_pkt(1, 7'b1_011_100);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid2", 32'(valid_slave2), 32'd1);
      check("t3_hold_data", 32'({addr_out, value_out}), 32'({3'd3, 3'd4}));
      check("t3_hold_nohs", 32'({handshake_slave1, handshake_slave2}), 32'd0);
      if (i < 9) tick();
    end
    ready_slave2 = 1'b1;
    tick();
    check("t3_hs2", 32'(handshake_slave2), 32'd1);
    tick();
    check_idle("t3_idle");

    // FIFO full with DEPTH=2
    do_reset();
    ready_slave1 = 1'b0;
    exp_q.push_back({2'b01, 7'b0_001_001});
    exp_q.push_back({2'b01, 7'b0_010_010});
    exp_q.push_back({2'b01, 7'b0_011_011});
    exp_q.push_back({2'b01, 7'b0_100_100});
    in_valid_1 = 1'b1; data_in_1 = 7'b0_001_001;
    tick();
    data_in_1 = 7'b0_010_010;
    tick();
    data_in_1 = 7'b0_011_011;
    tick();
    data_in_1 = 7'b0_100_100;
    check("t4_full_ready", 32'(in_ready_1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_full_ready_hold", 32'(in_ready_1), 32'd0);
      check("t4_first_send", 32'({valid_slave1, addr_out, value_out}), 32'({1'b1, 3'd1, 3'd1}));
    end
    ready_slave1 = 1'b1;
    tick();
    check("t4_hs1", 32'(handshake_slave1), 32'd1);
    check("t4_nobypass", 32'(in_ready_1), 32'd0);
    tick();
    check("t4_ready_back", 32'(in_ready_1), 32'd1);
    check("t4_second_send", 32'({valid_slave1, addr_out, value_out}), 32'({1'b1, 3'd2, 3'd2}));
    tick();
    in_valid_1 = 1'b0;
    drain(50);

    // Round-robin stress
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({2'b01, 1'(i & 1), 3'(i), 3'(7 - i)});
      exp_q.push_back({2'b10, 1'(~i & 1), 3'(i + 2), 3'(i)});
    end
    rr_mode = 1'b1;
    last_hs_cyc = -1;
    fork
      begin
        for (int i = 0; i < 6; i++) push_pkt(1, {1'(i & 1), 3'(i), 3'(7 - i)});
      end
      begin
        for (int j = 0; j < 6; j++) push_pkt(2, {1'(~j & 1), 3'(j + 2), 3'(j)});
      end
    join
    drain(100);
    rr_mode = 1'b0;

    // Mid-transfer reset with one packet queued
    do_reset();
    ready_slave1 = 1'b0;
    push_pkt(1, 7'b0_110_101);
    push_pkt(1, 7'b0_111_111);
    check("t6_in_send", 32'({valid_slave1, addr_out, value_out}), 32'({1'b1, 3'd6, 3'd5}));
    ready_slave1 = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_discarded", 32'({valid_slave1, valid_slave2}), 32'd0);
    end
    exp_q.push_back({2'b01, 7'b0_010_001});
    push_pkt(1, 7'b0_010_001);
    tick();
    check("t6_new_pkt", 32'({valid_slave1, addr_out, value_out}), 32'({1'b1, 3'd2, 3'd1}));
    drain(20);
    tick();
    check_idle("t6_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
